// File: rtl/mgmt_sram_bank_ctrl.sv
// Wishbone-classic slave onto NUM_BANKS single-port 32-bit SRAM banks with byte masks.
// Optional macro MGMT_SRAM_BANK_ERR_EN: out-of-range accesses respond with wb_err_o instead of wb_ack_o.
module mgmt_sram_bank_ctrl #(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned BANK_AW   = 8,
  parameter int unsigned READ_LAT  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     core_clk,
  input  logic                     core_rstn,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [3:0]               wb_sel_i,
  input  logic [31:0]              wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic [NUM_BANKS-1:0]     mem_ena,
  output logic [NUM_BANKS-1:0]     mem_wen,
  output logic [4*NUM_BANKS-1:0]   mem_wen_mask,
  output logic [BANK_AW-1:0]       mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [32*NUM_BANKS-1:0]  mem_rdata
);

  localparam int unsigned BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned CW = 2;
  localparam logic [32:0] REGION = 33'(NUM_BANKS) << (BANK_AW + 2);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bank_q, bank_d;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_q, dat_d;
  logic [NUM_BANKS-1:0]    ena_q, ena_d;
  logic [NUM_BANKS-1:0]    wen_q, wen_d;
  logic [4*NUM_BANKS-1:0]  mask_q, mask_d;
  logic [BANK_AW-1:0]      addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;

  logic [31:0]             off;
  logic                    hit;
  logic [BW-1:0]           bank_sel;
  logic [BANK_AW-1:0]      word_sel;

  assign off      = wb_adr_i - BASE_ADDR;
  assign hit      = {1'b0, off} < REGION;
  assign bank_sel = off[BANK_AW+2 +: BW];
  assign word_sel = off[BANK_AW+1:2];

`ifdef MGMT_SRAM_BANK_ERR_EN
  logic miss_q, miss_d, err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    ena_d   = '0;
    wen_d   = '0;
    mask_d  = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MGMT_SRAM_BANK_ERR_EN
    miss_d  = miss_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
`ifdef MGMT_SRAM_BANK_ERR_EN
          miss_d = !hit;
`endif
          if (!hit) begin
            dat_d   = '0;
            state_d = RESP;
          end else begin
            addr_d = word_sel;
            bank_d = bank_sel;
            if (wb_we_i) begin
              wdata_d = wb_dat_i;
              // An all-zero byte select still completes the cycle, but without touching memory.
              if (wb_sel_i != '0) begin
                for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                  if (bank_sel == BW'(b)) begin
                    ena_d[b]         = 1'b1;
                    wen_d[b]         = 1'b1;
                    mask_d[4*b +: 4] = wb_sel_i;
                  end
                end
              end
              state_d = RESP;
            end else begin
              for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (bank_sel == BW'(b)) ena_d[b] = 1'b1;
              end
              cnt_d   = CW'(READ_LAT - 1);
              state_d = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (bank_q == BW'(b)) dat_d = mem_rdata[32*b +: 32];
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (wb_cyc_i) begin
`ifdef MGMT_SRAM_BANK_ERR_EN
          ack_d = !miss_q;
          err_d = miss_q;
`else
          ack_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bank_q  <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      ena_q   <= '0;
      wen_q   <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MGMT_SRAM_BANK_ERR_EN
      miss_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      ena_q   <= ena_d;
      wen_q   <= wen_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef MGMT_SRAM_BANK_ERR_EN
      miss_q  <= miss_d;
      err_q   <= err_d;
`endif
    end
  end

  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = dat_q;
  assign mem_ena      = ena_q;
  assign mem_wen      = wen_q;
  assign mem_wen_mask = mask_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
`ifdef MGMT_SRAM_BANK_ERR_EN
  assign wb_err_o     = err_q;
`else
  assign wb_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_mgmt_sram_bank_ctrl.sv
// Directed bench for mgmt_sram_bank_ctrl: 2 banks x 256 words, READ_LAT=3, base 0.
// Miss-response expectations follow MGMT_SRAM_BANK_ERR_EN when it is defined.
module tb_mgmt_sram_bank_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [1:0]  mem_ena, mem_wen;
  logic [7:0]  mem_wen_mask;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [63:0] mem_rdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mgmt_sram_bank_ctrl #(
    .NUM_BANKS(2),
    .BANK_AW  (8),
    .READ_LAT (3),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .core_clk    (clk),
    .core_rstn   (rstn),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_we_i     (we),
    .wb_sel_i    (sel),
    .wb_adr_i    (adr),
    .wb_dat_i    (wdat),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .wb_err_o    (wb_err_o),
    .mem_ena     (mem_ena),
    .mem_wen     (mem_wen),
    .mem_wen_mask(mem_wen_mask),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Observation results of the last bus_req
  int          r_lat, r_pulses;
  logic        r_ack, r_err;
  logic [1:0]  r_ena, r_wen;
  logic [7:0]  r_mask, r_addr;
  logic [31:0] r_wdata;

  // Single-cycle strobe; inputs scrambled after the sample edge; waits up to 20 cycles for a response.
  task automatic bus_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    r_lat = 0; r_pulses = 0; r_ack = 1'b0; r_err = 1'b0;
    r_ena = '0; r_wen = '0; r_mask = '0; r_addr = '0; r_wdata = '0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk);
    #1;
    stb = 1'b0; adr = 32'hFFFF_FFF0; wdat = 32'h0BAD_0BAD; sel = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_ena != '0) begin
        r_pulses++;
        r_ena = mem_ena; r_wen = mem_wen; r_mask = mem_wen_mask; r_addr = mem_addr; r_wdata = mem_wdata;
      end
      if (wb_ack_o || wb_err_o) begin
        r_lat = k; r_ack = wb_ack_o; r_err = wb_err_o;
        break;
      end
    end
    cyc = 1'b0;
  endtask

  task automatic test_reset();
    int ena_seen;
    ena_seen = 0;
    rstn = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8; wdat = '0; sel = 4'hF;
    mem_rdata = {32'hAAAA_5555, 32'h1234_5678};
    repeat (3) begin
      @(negedge clk);
      if (mem_ena != '0) ena_seen++;
    end
    total++; if (ena_seen !== 0) $display("FAIL rst_ena_pulse got %0d exp 0", ena_seen); else passed++;
    total++; if ({wb_ack_o, wb_err_o} !== 2'b00) $display("FAIL rst_ack_err got %b exp 00", {wb_ack_o, wb_err_o}); else passed++;
    total++; if ({mem_wen, mem_wen_mask} !== 10'h0) $display("FAIL rst_wen_mask got %h exp 0", {mem_wen, mem_wen_mask}); else passed++;
    total++; if ({wb_dat_o, mem_addr, mem_wdata} !== 72'h0) $display("FAIL rst_data got %h exp 0", {wb_dat_o, mem_addr, mem_wdata}); else passed++;
    cyc = 1'b0; stb = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    bus_req(1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 4'b0101);
    total++; if (r_lat !== 2) $display("FAIL wr_latency got %0d exp 2", r_lat); else passed++;
    total++; if (r_pulses !== 1) $display("FAIL wr_pulses got %0d exp 1", r_pulses); else passed++;
    total++; if ({r_ena, r_wen} !== 4'b1010) $display("FAIL wr_ena_wen got %b exp 1010", {r_ena, r_wen}); else passed++;
    total++; if (r_mask !== 8'h50) $display("FAIL wr_mask got %h exp 50", r_mask); else passed++;
    total++; if (r_addr !== 8'h01) $display("FAIL wr_addr got %h exp 01", r_addr); else passed++;
    total++; if (r_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_wdata got %h exp deadbeef", r_wdata); else passed++;
    total++; if (wb_dat_o !== 32'h0) $display("FAIL wr_dat_hold got %h exp 0", wb_dat_o); else passed++;
    @(negedge clk);
    total++; if (wb_ack_o !== 1'b0) $display("FAIL wr_ack_width got %b exp 0", wb_ack_o); else passed++;
  endtask

  task automatic test_read();
    bus_req(1'b0, 32'h0000_0008, 32'h0, 4'hF);
    total++; if (r_lat !== 5) $display("FAIL rd0_latency got %0d exp 5", r_lat); else passed++;
    total++; if (r_pulses !== 1) $display("FAIL rd0_pulses got %0d exp 1", r_pulses); else passed++;
    total++; if ({r_ena, r_wen} !== 4'b0100) $display("FAIL rd0_ena_wen got %b exp 0100", {r_ena, r_wen}); else passed++;
    total++; if (r_addr !== 8'h02) $display("FAIL rd0_addr got %h exp 02", r_addr); else passed++;
    total++; if (wb_dat_o !== 32'h1234_5678) $display("FAIL rd0_data got %h exp 12345678", wb_dat_o); else passed++;
    bus_req(1'b0, 32'h0000_040C, 32'h0, 4'hF);
    total++; if (r_ena !== 2'b10) $display("FAIL rd1_ena got %b exp 10", r_ena); else passed++;
    total++; if (r_addr !== 8'h03) $display("FAIL rd1_addr got %h exp 03", r_addr); else passed++;
    total++; if (wb_dat_o !== 32'hAAAA_5555) $display("FAIL rd1_data got %h exp aaaa5555", wb_dat_o); else passed++;
  endtask

  task automatic test_miss_and_bounds();
    bus_req(1'b0, 32'h0000_0800, 32'h0, 4'hF);
    total++; if (r_pulses !== 0) $display("FAIL miss_rd_pulses got %0d exp 0", r_pulses); else passed++;
    total++; if (r_lat !== 2) $display("FAIL miss_rd_latency got %0d exp 2", r_lat); else passed++;
`ifdef MGMT_SRAM_BANK_ERR_EN
    total++; if ({r_ack, r_err} !== 2'b01) $display("FAIL miss_rd_resp got %b exp 01", {r_ack, r_err}); else passed++;
`else
    total++; if ({r_ack, r_err} !== 2'b10) $display("FAIL miss_rd_resp got %b exp 10", {r_ack, r_err}); else passed++;
`endif
    total++; if (wb_dat_o !== 32'h0) $display("FAIL miss_rd_data got %h exp 0", wb_dat_o); else passed++;
    bus_req(1'b1, 32'hFFFF_FFFC, 32'h5555_AAAA, 4'hF);
    total++; if (r_pulses !== 0) $display("FAIL miss_wr_pulses got %0d exp 0", r_pulses); else passed++;
    bus_req(1'b0, 32'h0000_07FF, 32'h0, 4'hF);
    total++; if ({r_ena, r_addr} !== {2'b10, 8'hFF}) $display("FAIL top_rd_ena_addr got %h exp 2ff", {r_ena, r_addr}); else passed++;
    total++; if (wb_dat_o !== 32'hAAAA_5555) $display("FAIL top_rd_data got %h exp aaaa5555", wb_dat_o); else passed++;
    bus_req(1'b1, 32'h0000_0010, 32'h1111_2222, 4'b0000);
    total++; if (r_pulses !== 0) $display("FAIL sel0_pulses got %0d exp 0", r_pulses); else passed++;
    total++; if ({r_lat, r_ack} !== {32'd2, 1'b1}) $display("FAIL sel0_resp got lat %0d ack %b exp lat 2 ack 1", r_lat, r_ack); else passed++;
  endtask

  task automatic test_abort();
    int resp_seen;
    resp_seen = 0;
    mem_rdata[31:0] = 32'hCAFE_F00D;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8; sel = 4'hF;
    @(posedge clk);
    #1 stb = 1'b0;
    @(negedge clk);
    cyc = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) resp_seen++;
    end
    total++; if (resp_seen !== 0) $display("FAIL abort_resp got %0d exp 0", resp_seen); else passed++;
    total++; if (wb_dat_o !== 32'hAAAA_5555) $display("FAIL abort_dat_hold got %h exp aaaa5555", wb_dat_o); else passed++;
    // Abort then a write sampled on the very next edge.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8;
    @(posedge clk);
    #1 stb = 1'b0;
    @(negedge clk);
    cyc = 1'b0;
    bus_req(1'b1, 32'h0000_0020, 32'h7654_3210, 4'b1100);
    total++; if ({r_lat, r_pulses} !== {32'd2, 32'd1}) $display("FAIL abort_next_wr got lat %0d pulses %0d exp 2 1", r_lat, r_pulses); else passed++;
    total++; if ({r_ena, r_mask, r_addr} !== {2'b01, 8'h0C, 8'h08}) $display("FAIL abort_next_wr_fields got %h exp 10c08", {r_ena, r_mask, r_addr}); else passed++;
  endtask

  task automatic test_reset_mid_read();
    int resp_seen;
    resp_seen = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8; sel = 4'hF;
    @(posedge clk);
    #1 stb = 1'b0;
    @(negedge clk);
    rstn = 1'b0; cyc = 1'b0;
    @(negedge clk);
    total++; if ({wb_ack_o, wb_err_o, mem_ena, mem_wen, mem_wen_mask} !== 14'h0) $display("FAIL midrst_ctrl got %h exp 0", {wb_ack_o, wb_err_o, mem_ena, mem_wen, mem_wen_mask}); else passed++;
    total++; if ({wb_dat_o, mem_addr, mem_wdata} !== 72'h0) $display("FAIL midrst_data got %h exp 0", {wb_dat_o, mem_addr, mem_wdata}); else passed++;
    rstn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) resp_seen++;
    end
    total++; if (resp_seen !== 0) $display("FAIL midrst_resp got %0d exp 0", resp_seen); else passed++;
    bus_req(1'b0, 32'h0000_0008, 32'h0, 4'hF);
    total++; if (r_lat !== 5) $display("FAIL midrst_rd_latency got %0d exp 5", r_lat); else passed++;
    total++; if (wb_dat_o !== 32'hCAFE_F00D) $display("FAIL midrst_rd_data got %h exp cafef00d", wb_dat_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_miss_and_bounds();
    test_abort();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
